// File: rtl/dac_write_module_if.sv
// Valid/ready sample stream from upstream DSP into the DAC write path.
interface dac_write_module_if #(
    parameter int DATA_W = 14
) ();
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_write_module.sv
// Buffers stream words in a small FIFO and presents one per divided conversion
// period to a parallel DAC; data changes on the dac_clk falling edge.
module dac_write_module #(
    parameter int                CLK_DIV    = 4,
    parameter int                DATA_W     = 14,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0] IDLE_CODE  = 14'h2000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    dac_write_module_if.slave             s,
    output logic                          dac_clk,
    output logic [DATA_W-1:0]             dac_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underflow_cnt,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       level_nxt;
    logic              fifo_empty;
    logic              pop_tick;
    logic              do_pop;
    logic              do_push;

    // s_ready depends only on the registered level, so a pop in the same
    // cycle never frees a slot for a push while full.
    assign s.s_ready = (fifo_level < LVL_FULL);

    always_comb begin
        fifo_empty = (fifo_level == '0);
        pop_tick   = enable && (cnt == CNT_LAST);
        do_pop     = pop_tick && !fifo_empty;
        do_push    = s.s_valid && s.s_ready;
        level_nxt  = fifo_level;
        case ({do_push, do_pop})
            2'b10:   level_nxt = fifo_level + 1'b1;
            2'b01:   level_nxt = fifo_level - 1'b1;
            default: level_nxt = fifo_level;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            dac_clk <= 1'b0;
        end else if (!enable) begin
            cnt     <= '0;
            dac_clk <= 1'b0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == CNT_RISE)
                dac_clk <= 1'b1;
            else if (cnt == CNT_LAST)
                dac_clk <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= s.s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_level    <= '0;
            dac_data      <= IDLE_CODE;
            underflow_cnt <= '0;
            busy          <= 1'b0;
        end else begin
            fifo_level <= level_nxt;
            busy       <= enable && (level_nxt != '0);
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                dac_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            // Empty at a pop tick: hold the last code and count the miss.
            if (pop_tick && fifo_empty && (underflow_cnt != '1))
                underflow_cnt <= underflow_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dac_write_module.sv
// Randomized bench for dac_write_module against a queue-based reference model.
module tb_dac_write_module;
    localparam int DATA_W  = 14;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;
    localparam logic [DATA_W-1:0] IDLE = 14'h2000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              dac_clk;
    logic [DATA_W-1:0] dac_data;
    logic [3:0]        fifo_level;
    logic [15:0]       underflow_cnt;
    logic              busy;

    dac_write_module_if #(.DATA_W(DATA_W)) s_if ();

    dac_write_module #(
        .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .IDLE_CODE(IDLE)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .s(s_if),
        .dac_clk(dac_clk), .dac_data(dac_data), .fifo_level(fifo_level),
        .underflow_cnt(underflow_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: m_k counts consecutive enabled edges; every CLK_DIV-th
    // one is a pop tick, and dac_clk is high in the second half of each period.
    int                m_k;
    logic [DATA_W-1:0] m_data;
    int                m_uf;
    logic [DATA_W-1:0] m_q[$];
    bit                m_busy;
    bit                m_popped;
    bit                m_pushed;

    logic [36:0] dut_vec;
    assign dut_vec = {dac_clk, dac_data, fifo_level, underflow_cnt, busy, s_if.s_ready};

    function automatic logic [36:0] exp_vec();
        logic clk_e;
        clk_e = ((m_k % CLK_DIV) >= CLK_DIV / 2);
        return {clk_e, m_data, 4'(m_q.size()), 16'(m_uf), m_busy, m_q.size() < DEPTH};
    endfunction

    task automatic model_reset();
        m_k = 0; m_data = IDLE; m_uf = 0; m_q.delete(); m_busy = 0;
        m_popped = 0; m_pushed = 0;
    endtask

    task automatic step();
        int pre;
        @(posedge clk);
        pre = m_q.size();
        m_popped = 0;
        m_pushed = 0;
        if (enable) m_k++; else m_k = 0;
        if (enable && (m_k % CLK_DIV == 0)) begin
            if (pre > 0) begin
                m_data = m_q.pop_front();
                m_popped = 1;
            end else if (m_uf < 65535) begin
                m_uf++;
            end
        end
        if (s_if.s_valid && pre < DEPTH) begin
            m_q.push_back(s_if.s_data);
            m_pushed = 1;
        end
        m_busy = enable && (m_q.size() != 0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; s_if.s_valid = 1'b0; s_if.s_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if ({dac_clk, dac_data, s_if.s_ready, underflow_cnt, fifo_level, busy} !==
                {1'b0, IDLE, 1'b1, 16'h0, 4'h0, 1'b0}) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got clk=%b data=%h rdy=%b uf=%0d lvl=%0d busy=%b",
                         i, dac_clk, dac_data, s_if.s_ready, underflow_cnt, fifo_level, busy);
            end
        end
    endtask

    task automatic test_basic();
        enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            s_if.s_valid = (i < 3);
            s_if.s_data  = 14'(i + 1);
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        s_if.s_valid = 1'b0;
        total++;
        if ({dac_data, underflow_cnt} !== {14'd3, 16'd3}) begin
            bad++;
            $display("FAIL basic_final got data=%h uf=%0d exp data=3 uf=3", dac_data, underflow_cnt);
        end
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] w[9];
        logic [DATA_W-1:0] got[$];
        for (int i = 0; i < 9; i++) w[i] = 14'($urandom);
        enable = 1'b0;
        s_if.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_if.s_data = w[(i < 8) ? i : 8];
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL full_fill cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if ({fifo_level, s_if.s_ready} !== {4'd8, 1'b0}) begin
            bad++;
            $display("FAIL full_level got lvl=%0d rdy=%b exp lvl=8 rdy=0", fifo_level, s_if.s_ready);
        end
        enable = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (m_pushed) s_if.s_valid = 1'b0;
            if (m_popped) got.push_back(dac_data);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL full_drain cyc=%0d got=%h exp=%h", j, dut_vec, exp_vec());
            end
            if (j == 4) begin
                total++;
                if ({fifo_level, s_if.s_ready} !== {4'd7, 1'b1}) begin
                    bad++;
                    $display("FAIL full_first_pop got lvl=%0d rdy=%b exp lvl=7 rdy=1",
                             fifo_level, s_if.s_ready);
                end
            end
            if (j == 5) begin
                total++;
                if (fifo_level !== 4'd8) begin
                    bad++;
                    $display("FAIL full_ninth_accept got lvl=%0d exp 8", fifo_level);
                end
            end
        end
        s_if.s_valid = 1'b0;
        total++;
        if (got.size() != 9) begin
            bad++;
            $display("FAIL full_count got=%0d exp=9", got.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                total++;
                if (got[i] !== w[i]) begin
                    bad++;
                    $display("FAIL full_order idx=%0d got=%h exp=%h", i, got[i], w[i]);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] base;
        int sent = 0;
        int pops = 0;
        int uf_ref = 0;
        int cyc = 0;
        base = 14'($urandom);
        enable = 1'b1;
        s_if.s_valid = 1'b1;
        s_if.s_data = base;
        while (pops < 200 && cyc < 1200) begin
            step();
            cyc++;
            if (m_pushed) begin
                sent++;
                s_if.s_data = 14'(base + 14'(sent));
            end
            if (cyc == 2 * CLK_DIV) uf_ref = m_uf;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
            if (m_popped) begin
                total++;
                if (dac_data !== 14'(base + 14'(pops))) begin
                    bad++;
                    $display("FAIL stream_seq pop=%0d got=%h exp=%h", pops, dac_data, 14'(base + 14'(pops)));
                end
                pops++;
            end
            if (cyc > 4 * CLK_DIV) begin
                total++;
                if (fifo_level < 4'd7) begin
                    bad++;
                    $display("FAIL stream_level cyc=%0d got=%0d exp>=7", cyc, fifo_level);
                end
            end
        end
        s_if.s_valid = 1'b0;
        total++;
        if (pops < 200 || underflow_cnt !== 16'(uf_ref)) begin
            bad++;
            $display("FAIL stream_end got pops=%0d uf=%0d exp pops=200 uf=%0d", pops, underflow_cnt, uf_ref);
        end
    endtask

    task automatic test_enable_drop();
        logic [DATA_W-1:0] w[5];
        int guard = 0;
        rst = 1'b1; enable = 1'b0; s_if.s_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w[i] = 14'($urandom);
            s_if.s_valid = 1'b1;
            s_if.s_data = w[i];
            step();
        end
        s_if.s_valid = 1'b0;
        enable = 1'b1;
        while (m_k != 6 && guard < 20) begin
            step();
            guard++;
        end
        total++;
        if (m_k != 6) begin
            bad++;
            $display("FAIL drop_sync got k=%0d exp=6", m_k);
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({dac_clk, dac_data, fifo_level} !== {1'b0, w[0], 4'd4} || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL drop_hold cyc=%0d got clk=%b data=%h lvl=%0d exp clk=0 data=%h lvl=4",
                         i, dac_clk, dac_data, fifo_level, w[0]);
            end
        end
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++;
            if (dac_data !== ((i < 4) ? w[0] : w[1]) || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL drop_resume cyc=%0d got data=%h exp=%h", i, dac_data, (i < 4) ? w[0] : w[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data = 14'($urandom);
            step();
        end
        s_if.s_valid = 1'b0;
        enable = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({dac_clk, dac_data, fifo_level, underflow_cnt, busy, s_if.s_ready} !==
            {1'b0, IDLE, 4'd0, 16'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_async got clk=%b data=%h lvl=%0d uf=%0d busy=%b rdy=%b",
                     dac_clk, dac_data, fifo_level, underflow_cnt, busy, s_if.s_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL reset_after cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if ({dac_data, underflow_cnt} !== {IDLE, 16'd5}) begin
            bad++;
            $display("FAIL reset_uf got data=%h uf=%0d exp data=2000 uf=5", dac_data, underflow_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            s_if.s_valid = ($urandom_range(0, 9) < 4);
            s_if.s_data = 14'($urandom);
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        s_if.s_valid = 1'b0;
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data = '0;
        test_reset();
        test_basic();
        test_full();
        test_stream();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
